// File: rtl/pds_target.sv
// pds_target: 68000-style PDS bus responder with a small 16-bit register bank.
// Bus strobes are synchronized to C16M; the cycle is decoded, held for a fixed
// number of wait states, then terminated with nDTACK (mapped slot) or nBERR (unmapped).
module pds_target #(
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned NREG        = 8,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] ID_VALUE    = 16'h5345
) (
  input  logic              C16M,
  input  logic              nRES,
  input  logic              nCS,
  input  logic              nAS,
  input  logic              nUDS,
  input  logic              nLDS,
  input  logic              RnW,
  input  logic [IDX_W-1:0]  A,
  input  logic [15:0]       Din,
  output logic [15:0]       Dout,
  output logic              nDoutOE,
  output logic              nDTACK,
  output logic              nBERR,
  output logic [NREG*16-1:0] REGS
);

  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [IDX_W:0] NREG_L = (IDX_W+1)'(NREG);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t          state, state_nx;
  logic [4:0]      sync1, sync2;
  logic [CW-1:0]   cnt;
  logic            hit_q;
  logic [15:0]     regs [NREG];
  logic [15:0]     rd_word;
  logic            as, cs, uds, lds, rnw;
  logic            hit_now;
  logic            enter_ack;
  logic            ack_hit;

  assign as  = ~sync2[4];
  assign cs  = ~sync2[3];
  assign uds = ~sync2[2];
  assign lds = ~sync2[1];
  assign rnw =  sync2[0];

  assign hit_now   = ({1'b0, A} < NREG_L);
  assign enter_ack = (state_nx == ST_ACK) && (state != ST_ACK);
  // With zero wait states ACK is entered straight from DECODE, before hit_q is valid.
  assign ack_hit   = (state == ST_DECODE) ? hit_now : hit_q;

  // Two-flop synchronizer for the asynchronous bus strobes (reset to inactive).
  always_ff @(posedge C16M or negedge nRES) begin
    if (!nRES) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {nAS, nCS, nUDS, nLDS, RnW};
      sync2 <= sync1;
    end
  end

  // Cycle state register.
  always_ff @(posedge C16M or negedge nRES) begin
    if (!nRES) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; AS negating before ACK aborts the cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (as && cs && (uds || lds)) state_nx = ST_DECODE;
      ST_DECODE: begin
        if (!as)                   state_nx = ST_IDLE;
        else if (WAIT_STATES == 0) state_nx = ST_ACK;
        else                       state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!as)                   state_nx = ST_IDLE;
        else if (cnt == CW'(1))    state_nx = ST_ACK;
      end
      ST_ACK:    if (!as) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Read mux: slot 0 is the fixed ID word.
  always_comb begin
    rd_word = ID_VALUE;
    for (int unsigned k = 1; k < NREG; k++)
      if (A == IDX_W'(k)) rd_word = regs[k];
  end

  // Register bank, read data, wait counter and bus termination outputs.
  always_ff @(posedge C16M or negedge nRES) begin
    if (!nRES) begin
      for (int unsigned k = 0; k < NREG; k++) regs[k] <= '0;
      Dout    <= '0;
      nDoutOE <= 1'b1;
      nDTACK  <= 1'b1;
      nBERR   <= 1'b1;
      cnt     <= '0;
      hit_q   <= 1'b0;
    end else begin
      case (state)
        ST_DECODE: begin
          if (as) begin
            hit_q <= hit_now;
            cnt   <= CW'(WAIT_STATES);
            if (!rnw && hit_now && (A != '0)) begin
              for (int unsigned k = 1; k < NREG; k++) begin
                if (A == IDX_W'(k)) begin
                  if (uds) regs[k][15:8] <= Din[15:8];
                  if (lds) regs[k][7:0]  <= Din[7:0];
                end
              end
            end
            if (rnw && hit_now) begin
              Dout    <= rd_word;
              nDoutOE <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (!as) nDoutOE <= 1'b1;
          else     cnt <= cnt - CW'(1);
        end
        ST_ACK: begin
          if (!as) begin
            nDTACK  <= 1'b1;
            nBERR   <= 1'b1;
            nDoutOE <= 1'b1;
          end
        end
        default: ;
      endcase
      if (enter_ack) begin
        if (ack_hit) nDTACK <= 1'b0;
        else         nBERR  <= 1'b0;
      end
    end
  end

  // Flattened register view for local logic; slot 0 reflects the ID word.
  always_comb begin
    REGS = '0;
    REGS[15:0] = ID_VALUE;
    for (int unsigned k = 1; k < NREG; k++) REGS[16*k +: 16] = regs[k];
  end

endmodule

// File: tb/tb_pds_target.sv
// tb_pds_target: directed bus cycles against a 2-wait-state and a 0-wait-state responder.
module tb_pds_target;

  logic        clk = 1'b0;
  logic        nres;
  logic        ncs, nas, nuds, nlds, rnw;
  logic [3:0]  a;
  logic [15:0] din;

  logic [15:0]  dout2, dout0;
  logic         noe2, noe0, ndtack2, ndtack0, nberr2, nberr0;
  logic [127:0] regs2, regs0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pds_target #(.IDX_W(4), .NREG(8), .WAIT_STATES(2), .ID_VALUE(16'h5345)) dut2 (
    .C16M(clk), .nRES(nres), .nCS(ncs), .nAS(nas), .nUDS(nuds), .nLDS(nlds), .RnW(rnw),
    .A(a), .Din(din), .Dout(dout2), .nDoutOE(noe2), .nDTACK(ndtack2), .nBERR(nberr2),
    .REGS(regs2)
  );

  pds_target #(.IDX_W(4), .NREG(8), .WAIT_STATES(0), .ID_VALUE(16'h5345)) dut0 (
    .C16M(clk), .nRES(nres), .nCS(ncs), .nAS(nas), .nUDS(nuds), .nLDS(nlds), .RnW(rnw),
    .A(a), .Din(din), .Dout(dout0), .nDoutOE(noe0), .nDTACK(ndtack0), .nBERR(nberr0),
    .REGS(regs0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    nas = 1'b1; ncs = 1'b1; nuds = 1'b1; nlds = 1'b1; rnw = 1'b1;
  endtask

  // One full bus cycle; edges counted from E1 (first posedge after strobes assert).
  task automatic do_cycle(input string tag, input bit rd, input logic [3:0] adr,
                          input logic [15:0] wd, input bit u, input bit l,
                          input bit hit, input logic [15:0] exp_rd);
    @(negedge clk);
    rnw = rd; a = adr; din = wd; ncs = 1'b0; nas = 1'b0; nuds = ~u; nlds = ~l;
    repeat (3) @(posedge clk);
    #1 check({tag, " dtack2 E3"}, ndtack2, 1);
    @(posedge clk); #1;
    check({tag, " dtack0 E4"}, ndtack0, !hit);
    check({tag, " berr0 E4"}, nberr0, hit);
    if (rd && hit) begin
      check({tag, " oe2 E4"}, noe2, 0);
      check({tag, " dout2 E4"}, dout2, exp_rd);
    end
    @(posedge clk); #1;
    check({tag, " dtack2 E5"}, ndtack2, 1);
    check({tag, " berr2 E5"}, nberr2, 1);
    @(posedge clk); #1;
    check({tag, " dtack2 E6"}, ndtack2, !hit);
    check({tag, " berr2 E6"}, nberr2, hit);
    check({tag, " oe2 E6"}, noe2, !(rd && hit));
    @(negedge clk);
    bus_idle();
    repeat (2) @(posedge clk);
    #1 check({tag, " dtack2 held"}, ndtack2, !hit);
    @(posedge clk); #1;
    check({tag, " dtack2 rel"}, ndtack2, 1);
    check({tag, " berr2 rel"}, nberr2, 1);
    check({tag, " oe2 rel"}, noe2, 1);
    check({tag, " dtack0 rel"}, ndtack0, 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    bus_idle();
    a = '0; din = '0; nres = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst dtack", ndtack2, 1);
    check("rst berr", nberr2, 1);
    check("rst oe", noe2, 1);
    check("rst dout", dout2, 0);
    check("rst regs", regs2[127:16], 0);
    check("rst slot0", regs2[15:0], 16'h5345);
    @(negedge clk) nres = 1'b1;
    repeat (2) @(posedge clk);

    // 1: ID read
    do_cycle("rd id", 1, 4'd0, 16'h0000, 1, 1, 1, 16'h5345);
    // 2: word write then upper-byte write, read back
    do_cycle("wr3 word", 0, 4'd3, 16'hA55A, 1, 1, 1, 16'h0000);
    check("regs3 word", regs2[63:48], 16'hA55A);
    do_cycle("wr3 upper", 0, 4'd3, 16'h12FF, 1, 0, 1, 16'h0000);
    check("regs3 upper", regs2[63:48], 16'h125A);
    check("regs3 upper ws0", regs0[63:48], 16'h125A);
    do_cycle("rd3", 1, 4'd3, 16'h0000, 1, 1, 1, 16'h125A);
    do_cycle("wr5 lower", 0, 4'd5, 16'hBEEF, 0, 1, 1, 16'h0000);
    check("regs5 lower", regs2[95:80], 16'h00EF);
    // 3: unmapped slot
    do_cycle("rd12", 1, 4'd12, 16'h0000, 1, 1, 0, 16'h0000);
    // 4: write to ID slot is acked but ignored
    do_cycle("wr0", 0, 4'd0, 16'hFFFF, 1, 1, 1, 16'h0000);
    do_cycle("rd id2", 1, 4'd0, 16'h0000, 1, 1, 1, 16'h5345);

    // 5: aborted cycle, AS negated after E3
    @(negedge clk);
    rnw = 1'b1; a = 4'd1; ncs = 1'b0; nas = 1'b0; nlds = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) bus_idle();
    for (int i = 4; i <= 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort dtack E%0d", i), ndtack2, 1);
      check($sformatf("abort berr E%0d", i), nberr2, 1);
    end
    check("abort oe", noe2, 1);
    do_cycle("rd3 post abort", 1, 4'd3, 16'h0000, 1, 1, 1, 16'h125A);

    // 6: reset while in ACK
    @(negedge clk);
    rnw = 1'b1; a = 4'd3; ncs = 1'b0; nas = 1'b0; nuds = 1'b0; nlds = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("ack before rst", ndtack2, 0);
    check("oe before rst", noe2, 0);
    #2 nres = 1'b0;
    #1;
    check("rst async dtack", ndtack2, 1);
    check("rst async oe", noe2, 1);
    check("rst async dtack0", ndtack0, 1);
    check("rst regs3", regs2[63:48], 0);
    check("rst regs5", regs2[95:80], 0);
    bus_idle();
    @(negedge clk) nres = 1'b1;
    repeat (2) @(posedge clk);
    do_cycle("rd id rst", 1, 4'd0, 16'h0000, 1, 1, 1, 16'h5345);
    do_cycle("rd3 rst", 1, 4'd3, 16'h0000, 1, 1, 1, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
